// File: rtl/pll_reset_ce_gen.sv
// Qualifies PLL lock, sequences the core reset and generates phase-aligned clock enables.
// All outputs are registered; enables run during the reset hold so synchronous-reset logic sees enabled edges.
module pll_reset_ce_gen #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD         = 16,
   parameter int CE_DIV             = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic locked_in,
   input  logic reset_req,
   output logic reset_out,
   output logic ce_p,
   output logic ce_n,
   output logic ce_fast,
   output logic locked_sync
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD) ? LOCK_STABLE_CYCLES : RESET_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int DIV_W   = $clog2(CE_DIV);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
   localparam logic [DIV_W-1:0] DIV_P       = DIV_W'(CE_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_N       = DIV_W'(CE_DIV / 2 - 1);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] STABLE    = 2'd1;
   localparam logic [1:0] HOLD      = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             reset_out_q, reset_out_d;
   logic             ce_p_q, ce_p_d;
   logic             ce_n_q, ce_n_d;
   logic             ce_fast_q, ce_fast_d;
   logic             en_run;

   always_comb begin
      sync1_d = locked_in;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      // Lock loss outranks a soft-reset request, which outranks counting.
      case (state_q)
         WAIT_LOCK: begin
            if (sync2_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         end
         STABLE: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (reset_req) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (reset_req) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // The divider restarts only when the hold is first entered; a soft reset keeps the enable phase.
   always_comb begin
      en_run = (state_d == HOLD) || (state_d == RUN);
      if (!en_run || (state_q == STABLE)) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end
      reset_out_d = (state_d != RUN);
      ce_p_d      = en_run && (div_d == DIV_P);
      ce_n_d      = en_run && (div_d == DIV_N);
      ce_fast_d   = en_run && (div_d[1:0] == 2'b11);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         div_q       <= '0;
         reset_out_q <= 1'b1;
         ce_p_q      <= 1'b0;
         ce_n_q      <= 1'b0;
         ce_fast_q   <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         reset_out_q <= reset_out_d;
         ce_p_q      <= ce_p_d;
         ce_n_q      <= ce_n_d;
         ce_fast_q   <= ce_fast_d;
      end
   end

   assign reset_out   = reset_out_q;
   assign ce_p        = ce_p_q;
   assign ce_n        = ce_n_q;
   assign ce_fast     = ce_fast_q;
   assign locked_sync = sync2_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Bench for pll_reset_ce_gen: an edge-count model of lock qualification, reset hold and
// enable phase is compared every cycle, plus literal expectations at hand-computed edges.
module tb_pll_reset_ce_gen;

   localparam int LSC = 8;
   localparam int RH  = 4;
   localparam int CED = 16;

   logic clk = 1'b0;
   logic rst;
   logic locked_in;
   logic reset_req;
   logic reset_out, ce_p, ce_n, ce_fast, locked_sync;

   int nvec = 0;
   int nerr = 0;
   int ecnt = 0;
   int e0   = 0;

   // Model state: synchronizer queue, run length of locked samples, key edge stamps.
   logic m_s1 = 1'b0, m_s2 = 1'b0;
   logic m_rst = 1'b1, m_p = 1'b0, m_n = 1'b0, m_f = 1'b0;
   int   m_l = 0, m_hold_e = 0, m_zero_e = 0, m_ph = 0;

   pll_reset_ce_gen #(
      .LOCK_STABLE_CYCLES(LSC),
      .RESET_HOLD(RH),
      .CE_DIV(CED)
   ) dut (
      .clk(clk),
      .rst(rst),
      .locked_in(locked_in),
      .reset_req(reset_req),
      .reset_out(reset_out),
      .ce_p(ce_p),
      .ce_n(ce_n),
      .ce_fast(ce_fast),
      .locked_sync(locked_sync)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {reset_out, ce_p, ce_n, ce_fast, locked_sync};
   endfunction

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s edge %0d: got %b expected %b (reset_out,ce_p,ce_n,ce_fast,locked_sync)",
                  name, ecnt - e0, act, exp);
      end
   endtask

   task automatic goto_edge(input int n);
      while (ecnt < e0 + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_lock();
      @(negedge clk);
      locked_in = 1'b1;
      e0 = ecnt + 1;
   endtask

   // Power-up timeline relative to the first edge that samples locked_in=1.
   task automatic pu_checks(input string tag);
      goto_edge(0);  chk({tag, "_e0"},  outs(), 5'b10000);
      goto_edge(1);  chk({tag, "_e1"},  outs(), 5'b10001);
      goto_edge(5);  chk({tag, "_e5"},  outs(), 5'b10001);
      goto_edge(9);  chk({tag, "_e9"},  outs(), 5'b10001);
      goto_edge(12); chk({tag, "_e12"}, outs(), 5'b10001);
      goto_edge(13); chk({tag, "_e13"}, outs(), 5'b10011);
      goto_edge(14); chk({tag, "_e14"}, outs(), 5'b00001);
      goto_edge(17); chk({tag, "_e17"}, outs(), 5'b00111);
      goto_edge(25); chk({tag, "_e25"}, outs(), 5'b01011);
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_l = 0;
            m_rst = 1'b1; m_p = 1'b0; m_n = 1'b0; m_f = 1'b0;
         end else begin
            ecnt++;
            m_l  = m_s2 ? m_l + 1 : 0;
            m_s2 = m_s1;
            m_s1 = locked_in;
            if (m_l == LSC + 1) begin
               m_hold_e = ecnt;
               m_zero_e = ecnt;
            end else if (m_l > LSC + 1 && reset_req) begin
               m_zero_e = ecnt;
            end
            if (m_l > LSC) begin
               m_ph  = (ecnt - m_hold_e) % CED;
               m_p   = (m_ph == CED - 1);
               m_n   = (m_ph == CED / 2 - 1);
               m_f   = (m_ph % 4 == 3);
               m_rst = (ecnt - m_zero_e) < RH;
            end else begin
               m_p = 1'b0; m_n = 1'b0; m_f = 1'b0; m_rst = 1'b1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) chk("model", outs(), {m_rst, m_p, m_n, m_f, m_s2});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: scenario did not complete, got timeout required finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; locked_in = 1'b0; reset_req = 1'b0;
      #23;
      chk("reset_state", outs(), 5'b10000);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      start_lock();
      pu_checks("powerup");

      goto_edge(33); chk("run_ce_n", outs(), 5'b00111);
      goto_edge(41); chk("run_ce_p", outs(), 5'b01011);

      // Single-cycle soft reset, then a held one.
      goto_edge(49);
      @(negedge clk); reset_req = 1'b1;
      goto_edge(50); chk("req_pulse_e50", outs(), 5'b10001);
      @(negedge clk); reset_req = 1'b0;
      goto_edge(53); chk("req_pulse_e53", outs(), 5'b10011);
      goto_edge(54); chk("req_pulse_e54", outs(), 5'b00001);
      goto_edge(57); chk("req_phase_e57", outs(), 5'b01011);
      goto_edge(59);
      @(negedge clk); reset_req = 1'b1;
      goto_edge(69);
      @(negedge clk); reset_req = 1'b0;
      goto_edge(72); chk("req_held_e72", outs(), 5'b10001);
      goto_edge(73); chk("req_held_e73", outs(), 5'b01011);

      // Lock loss in RUN, sampled at edge 90.
      goto_edge(89);
      @(negedge clk); locked_in = 1'b0;
      goto_edge(91); chk("lockloss_e91", outs(), 5'b00000);
      goto_edge(92); chk("lockloss_e92", outs(), 5'b10000);
      goto_edge(99);
      start_lock();
      pu_checks("relock");

      // Three-cycle lock glitch while stable-counting.
      goto_edge(30);
      @(negedge clk); locked_in = 1'b0;
      goto_edge(35);
      start_lock();
      goto_edge(5);
      @(negedge clk); locked_in = 1'b0;
      goto_edge(8);
      start_lock();
      pu_checks("glitch");

      // Async reset mid-RUN, on a ce_p cycle.
      goto_edge(41);
      #2 rst = 1'b1;
      #1 chk("arst_run", outs(), 5'b10000);
      @(negedge clk); rst = 1'b0; e0 = ecnt + 1;
      pu_checks("arst_run");

      // Async reset mid-HOLD.
      goto_edge(11);
      #2 rst = 1'b1;
      #1 chk("arst_hold", outs(), 5'b10000);
      @(negedge clk); rst = 1'b0; e0 = ecnt + 1;
      pu_checks("arst_hold");

      goto_edge(60);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pll_reset_ce_gen.md
Name: pll_reset_ce_gen

Overview:
Sits directly downstream of the system PLL. Runs on the PLL's 24 MHz output. Qualifies the PLL lock indication and produces the core-wide reset. Generates the phase-aligned clock enables (1.5 MHz CPU/PSG phases, 6 MHz fast enable) that every core block uses instead of derived clocks. The rest of the core stays in reset until the PLL has been locked and stable for a programmable time, and it is pushed back into reset immediately on lock loss.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before reset release sequence starts (>=2)
RESET_HOLD, 16, cycles reset_out stays asserted while enables already run (>=2)
CE_DIV, 16, CPU enable divide ratio; power of two, >=8 (24 MHz/16 = 1.5 MHz)

Ports:
clk  in  1  core clock, 24 MHz PLL output
rst  in  1  asynchronous active-high reset
locked_in  in  1  PLL lock, asynchronous to clk
reset_req  in  1  synchronous soft-reset request (level or pulse) from OSD/user
reset_out  out  1  core reset, active-high, registered
ce_p  out  1  CPU rising-phase enable, 1 clk wide, once per CE_DIV cycles
ce_n  out  1  CPU falling-phase enable, 1 clk wide, CE_DIV/2 cycles after ce_p
ce_fast  out  1  enable every 4th clk (6 MHz)
locked_sync  out  1  2-flop synchronized locked_in

Behaviour:
- Async rst: sync flops = 0, state = WAIT_LOCK, counters = 0, div = 0, reset_out = 1, ce_p/ce_n/ce_fast = 0, locked_sync = 0.
- locked_in passes through a 2-flop synchronizer.
  - locked_sync is the second flop.
  - Only locked_sync is used internally.
- State machine; cnt is a shared counter sized for max(LOCK_STABLE_CYCLES, RESET_HOLD).
  - WAIT_LOCK: locked_sync=1 -> STABLE, cnt=0.
  - STABLE: locked_sync=0 -> WAIT_LOCK. Else if cnt==LOCK_STABLE_CYCLES-1 -> HOLD, cnt=0. Else cnt++.
  - HOLD: locked_sync=0 -> WAIT_LOCK. Else if reset_req=1 -> cnt=0 (hold is extended). Else if cnt==RESET_HOLD-1 -> RUN. Else cnt++.
  - RUN: locked_sync=0 -> WAIT_LOCK. Else if reset_req=1 -> HOLD, cnt=0.
- Priority: lock loss > reset_req > counting.
- reset_out is registered from next-state: reset_out <= (next_state != RUN). It is glitch-free and changes on the same edge as the state.
- Latency, counting edge 0 as the first edge sampling locked_in=1:
  - STABLE is entered at edge 2.
  - reset_out falls at edge 2+LOCK_STABLE_CYCLES+RESET_HOLD.
- Lock loss latency: reset_out rises at edge 2 after the first edge sampling locked_in=0. A lock glitch shorter than 1 clk may be missed; a glitch seen by the synchronizer always restarts from WAIT_LOCK.
- Divider div, log2(CE_DIV) bits:
  - Forced to 0 in WAIT_LOCK and STABLE, and on entering HOLD from STABLE.
  - Increments every cycle in HOLD and RUN, wrapping CE_DIV-1 -> 0.
  - Soft reset (RUN -> HOLD) does not clear div, so enable phase is continuous across soft reset.
- Enables are registered and derived from next-div, valid only when next_state is HOLD or RUN (else 0):
  - ce_p = (next_div == CE_DIV-1).
  - ce_n = (next_div == CE_DIV/2-1).
  - ce_fast = (next_div[1:0] == 3).
- ce_p and ce_n are never high together. ce_fast is high on every cycle ce_p or ce_n is high.
- Enables run during HOLD so synchronous-reset logic in the core observes enabled edges.

Test Plan:
Use LOCK_STABLE_CYCLES=8, RESET_HOLD=4, CE_DIV=16; rst pulsed then released with locked_in=0.
1. Power-up: locked_in=1 sampled at edge 0 -> reset_out=1 through edge 13, falls at edge 14. ce_fast first high at edge 13. First ce_n at edge 17, first ce_p at edge 25. Enables 0 before edge 10.
2. Steady run -> ce_p period exactly 16 clks, ce_n 8 clks after each ce_p, ce_fast period 4, never ce_p&ce_n.
3. Lock drops 3 cycles in STABLE (cnt<7) -> returns to WAIT_LOCK. After relock, the full 8+4 sequence restarts and reset_out never deasserts early.
4. Lock loss in RUN, sampled at edge k -> reset_out=1 and all enables 0 from edge k+2; div=0. Relock reproduces scenario 1 timing.
5. reset_req 1-cycle pulse in RUN -> reset_out high next edge for exactly 4 cycles. ce_p phase unchanged (still every 16 from the original alignment). reset_req held 10 cycles -> reset_out low 4 cycles after reset_req drops.
6. Async rst asserted mid-HOLD and mid-RUN -> immediately reset_out=1, enables 0, locked_sync=0. After release with locked_in=1, reset_out falls 14 edges later.
